// File: rtl/tp_lpf_sched.sv
// Shared first-order IIR low-pass engine for six AY channels; one diff/mul/acc datapath stepped by an FSM.
// Latency: out_flat/out_valid 19 clocks after sample_cen; a strobe while busy is dropped and sets sticky overrun. Optional mix output: LPF_MIX_EN.
module tp_lpf_sched #(
    parameter logic [15:0] K_LIGHT = 16'd23466,
    parameter logic [15:0] K_MED   = 16'd5921,
    parameter logic [15:0] K_HEAVY = 16'd4919
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_cen,
    input  logic [95:0] in_flat,
    input  logic [11:0] sel,
    output logic [95:0] out_flat,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
`ifdef LPF_MIX_EN
    ,
    output logic [15:0] mix
`endif
);

    typedef enum logic [2:0] {IDLE, RD, MUL, WB, DONE} state_t;

    state_t             state_q;
    logic [2:0]         ch_q;
    logic signed [15:0] x_snap_q [6];
    logic [1:0]         sel_snap_q [6];
    logic signed [15:0] y_q [6];
    logic signed [15:0] shadow_q [6];
    logic signed [16:0] diff_q;
    logic [15:0]        k_q;
    logic signed [32:0] prod_q;
    logic [95:0]        out_flat_q;
    logic               out_valid_q;
    logic               overrun_q;

    logic signed [16:0] diff_d;
    logic [15:0]        k_d;
    logic signed [32:0] diff_ext;
    logic signed [32:0] k_ext;
    logic signed [32:0] prod_d;
    logic signed [17:0] sum18;
    logic signed [15:0] wb_d;

    always_comb begin
        diff_d   = {x_snap_q[ch_q][15], x_snap_q[ch_q]} - {y_q[ch_q][15], y_q[ch_q]};
        case (sel_snap_q[ch_q])
            2'b01:   k_d = K_LIGHT;
            2'b10:   k_d = K_MED;
            2'b11:   k_d = K_HEAVY;
            default: k_d = 16'd0;
        endcase
        diff_ext = {{16{diff_q[16]}}, diff_q};
        k_ext    = {17'd0, k_q};
        prod_d   = diff_ext * k_ext;
        // Upper bits of the product are the floor-shifted step toward x.
        sum18    = {{2{y_q[ch_q][15]}}, y_q[ch_q]} + {prod_q[32], prod_q[32:16]};
        if (sum18 > 18'sd32767)
            wb_d = 16'sh7FFF;
        else if (sum18 < -18'sd32768)
            wb_d = 16'sh8000;
        else
            wb_d = sum18[15:0];
        if (sel_snap_q[ch_q] == 2'b00)
            wb_d = x_snap_q[ch_q];
    end

`ifdef LPF_MIX_EN
    logic [15:0] mix_q;
    logic [15:0] mix_d;
    logic [15:0] acc;

    always_comb begin
        acc = 16'd0;
        for (int i = 0; i < 6; i++)
            acc = acc + shadow_q[i];
        mix_d = 16'hFFFF - acc;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mix_q <= 16'hFFFF;
        else if (state_q == DONE)
            mix_q <= mix_d;
    end

    assign mix = mix_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= 3'd0;
            diff_q      <= '0;
            k_q         <= '0;
            prod_q      <= '0;
            out_flat_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                x_snap_q[i]   <= '0;
                sel_snap_q[i] <= '0;
                y_q[i]        <= '0;
                shadow_q[i]   <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (sample_cen && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (sample_cen) begin
                        for (int i = 0; i < 6; i++) begin
                            x_snap_q[i]   <= in_flat[16*i +: 16];
                            sel_snap_q[i] <= sel[2*i +: 2];
                        end
                        ch_q    <= 3'd0;
                        state_q <= RD;
                    end
                end
                RD: begin
                    diff_q  <= diff_d;
                    k_q     <= k_d;
                    state_q <= MUL;
                end
                MUL: begin
                    prod_q  <= prod_d;
                    state_q <= WB;
                end
                WB: begin
                    y_q[ch_q]      <= wb_d;
                    shadow_q[ch_q] <= wb_d;
                    if (ch_q == 3'd5) begin
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + 3'd1;
                        state_q <= RD;
                    end
                end
                DONE: begin
                    for (int i = 0; i < 6; i++)
                        out_flat_q[16*i +: 16] <= shadow_q[i];
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_flat  = out_flat_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/tp_lpf_sched.md
Name: tp_lpf_sched

Overview:
Time-multiplexed low-pass filter engine for the sound board's six AY-3-8910 channels (2 chips × A/B/C). It replaces 18 parallel first-order IIR filters with one shared subtract/multiply/accumulate datapath. A scheduler FSM steps through the six channels once per audio sample, applying the per-channel filter strength (bypass/light/medium/heavy). Sits between the DC-offset removers and the final mixer.

Parameters:
K_LIGHT, 23466, Q0.16 coefficient for 3386.28 Hz cutoff at 48 kHz sample rate
K_MED, 5921, Q0.16 coefficient for 723.43 Hz cutoff
K_HEAVY, 4919, Q0.16 coefficient for 596.09 Hz cutoff

Ports:
clk  in  1  system clock (49.152 MHz)
reset  in  1  synchronous, active-high reset
sample_cen  in  1  one-cycle sample strobe (nominally clk/1024)
in_flat  in  96  six signed 16-bit inputs; channel n = bits [16n+15:16n], order ay1A, ay1B, ay1C, ay2A, ay2B, ay2C
sel  in  12  six 2-bit filter selects, channel n = bits [2n+1:2n]; 00 bypass, 01 light, 10 medium, 11 heavy
out_flat  out  96  six signed 16-bit filtered outputs, same packing as in_flat
out_valid  out  1  one-cycle pulse when out_flat updates
busy  out  1  high while the FSM is not IDLE
overrun  out  1  sticky flag: sample_cen arrived while busy

Behaviour:
- Reset (sync, active-high; dominates all other inputs): FSM to IDLE; ch=0; all y[0..5]=0; out_flat=0; out_valid=0; overrun=0; snapshot registers=0.
- FSM states: IDLE, RD, MUL, WB, DONE. busy = (state != IDLE).
- IDLE: on sample_cen, capture in_flat and sel into snapshot registers, set ch=0, go to RD. Live in_flat/sel changes after this edge do not affect the current pass.
- RD: diff = x[ch] − y[ch], 17-bit signed, registered. Select k from sel_snap[ch]. Go to MUL.
- MUL: prod = diff × k (17-bit signed × 16-bit unsigned as signed 33-bit), registered. Go to WB.
- WB: bypass sets y[ch] ← x[ch]. Otherwise y[ch] ← sat16(y[ch] + (prod >>> 16)), using an arithmetic shift (floor toward −∞) and saturation to [−32768, 32767]. Write the result to the shadow output. If ch=5, go to DONE; else ch+1 and go to RD.
- DONE: copy all six shadow values to out_flat atomically, pulse out_valid for one cycle, go to IDLE.
- Timing: strobe sampled at edge E0. Channel n written at E(3n+3); ch5 at E18. out_flat update and out_valid at E19. Minimum strobe spacing is 20 clocks.
- Any sample_cen sampled while busy (E1..E19) is ignored and sets overrun=1. overrun clears only on reset.
- Bypass keeps y tracking x, so a later switch to a filtered mode starts with no step transient.
- Changing a filter mode mid-stream takes effect at the next sample only. The y state is retained across mode changes.
- out_flat holds its value between out_valid pulses.

Optional Feature:
LPF_MIX_EN:
- Defined: adds output port mix (out, 16) = 16'hFFFF − (sum of six out_flat channels), modulo 2^16. This is the inverting-amp mix. It is registered at E19 with out_flat, and reset to 16'hFFFF.
- Undefined: port and adder are absent.

Test Plan:
1. Assert reset, then release → out_flat=0, out_valid=0, busy=0, overrun=0; busy=1 for 19 cycles after the first strobe.
2. Bypass: sel=0, ch0=1000, ch5=−3000, one strobe → out_valid exactly 19 edges after the strobe edge; ch0=1000, ch5=−3000, others 0.
3. Light step: sel[1:0]=01, ch0=16384 held, two strobes 1024 clocks apart → ch0=5866 after the first, then 9632 after the second.
4. Heavy negative: sel[1:0]=11, ch0=−8192 from reset → ch0=−615 (floor); a medium channel fed 32767 for 2000 samples never exceeds 32767.
5. Overrun: strobe, then a second strobe 10 clocks later → only one out_valid pulse, results identical to the single-strobe case, overrun=1 until reset.
6. Reset at clock 8 of a pass → no out_valid; all y cleared; the next strobe reproduces scenario 3's first value (5866).
